// File: rtl/program_loader.sv
// Loads host program bytes into the CPU RAM and holds the core in reset while loading.
// Host pins are asynchronous and pass through synchronizer chains before use.
module program_loader #(
    parameter int RAM_BYTES   = 16,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_mode,
    input  logic              load_strobe,
    input  logic [7:0]        load_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              load_ack,
    output logic              full,
    output logic              cpu_rst_n
);

    typedef enum logic [2:0] {
        IDLE,
        PROG,
        WRITE,
        HOLD,
        RUN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] prog_sync_q, prog_sync_d;
    logic [SYNC_STAGES-1:0] strobe_sync_q, strobe_sync_d;
    logic                   strobe_dly_q, strobe_dly_d;
    logic [ADDR_W-1:0]      ptr_q, ptr_d;
    logic                   full_q, full_d;
    logic                   ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]      ram_addr_q, ram_addr_d;
    logic [7:0]             ram_wdata_q, ram_wdata_d;
    logic                   load_ack_q, load_ack_d;
    logic                   cpu_rst_n_q, cpu_rst_n_d;

    logic prog_s;
    logic strobe_s;
    logic strobe_rise;

    assign prog_s      = prog_sync_q[SYNC_STAGES-1];
    assign strobe_s    = strobe_sync_q[SYNC_STAGES-1];
    assign strobe_rise = strobe_s & ~strobe_dly_q;

    always_comb begin
        prog_sync_d   = {prog_sync_q[SYNC_STAGES-2:0], prog_mode};
        strobe_sync_d = {strobe_sync_q[SYNC_STAGES-2:0], load_strobe};
        strobe_dly_d  = strobe_s;
        state_d       = state_q;
        ptr_d         = ptr_q;
        full_d        = full_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        load_ack_d    = load_ack_q;
        // The write pulse is the registered image of the WRITE state
        ram_we_d      = (state_q == WRITE);

        unique case (state_q)
            IDLE: begin
                load_ack_d = 1'b0;
                state_d    = prog_s ? PROG : RUN;
            end
            PROG: begin
                load_ack_d = 1'b0;
                if (!prog_s) begin
                    state_d = RUN;
                end else if (strobe_rise) begin
                    if (full_q) begin
                        state_d = HOLD;
                    end else begin
                        ram_wdata_d = load_data;
                        state_d     = WRITE;
                    end
                end
            end
            WRITE: begin
                ram_addr_d = ptr_q;
                load_ack_d = 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    ptr_d  = '0;
                    full_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (!prog_s) begin
                    load_ack_d = 1'b0;
                    state_d    = RUN;
                end else if (!strobe_s) begin
                    load_ack_d = 1'b0;
                    state_d    = PROG;
                end
            end
            RUN: begin
                if (prog_s) begin
                    ptr_d   = '0;
                    full_d  = 1'b0;
                    state_d = PROG;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cpu_rst_n_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            prog_sync_q   <= '0;
            strobe_sync_q <= '0;
            strobe_dly_q  <= 1'b0;
            ptr_q         <= '0;
            full_q        <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            load_ack_q    <= 1'b0;
            cpu_rst_n_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            prog_sync_q   <= prog_sync_d;
            strobe_sync_q <= strobe_sync_d;
            strobe_dly_q  <= strobe_dly_d;
            ptr_q         <= ptr_d;
            full_q        <= full_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            load_ack_q    <= load_ack_d;
            cpu_rst_n_q   <= cpu_rst_n_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign load_ack  = load_ack_q;
    assign full      = full_q;
    assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load, full, held strobe,
// run/program transitions and asynchronous reset during a write.
module tb_program_loader;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       prog_mode = 1'b0;
    logic       load_strobe = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       load_ack;
    logic       full;
    logic       cpu_rst_n;

    program_loader #(
        .RAM_BYTES  (16),
        .ADDR_W     (4),
        .SYNC_STAGES(SS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_mode  (prog_mode),
        .load_strobe(load_strobe),
        .load_data  (load_data),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .load_ack   (load_ack),
        .full       (full),
        .cpu_rst_n  (cpu_rst_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int we_cnt, we_lat, ack_first, ack_last, rst_hi, full_end;
    logic [3:0] we_addr;
    logic [7:0] we_data;
    int mode_lat;
    int found;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe one byte: high for hi edges, low for lo edges, recording activity.
    task automatic send(input logic [7:0] d, input int hi, input int lo);
        we_cnt = 0; we_lat = 0; ack_first = 0; ack_last = 0; rst_hi = 0;
        we_addr = '0; we_data = '0;
        load_data = d;
        load_strobe = 1'b1;
        for (int i = 1; i <= hi + lo; i++) begin
            tick();
            if (ram_we) begin
                we_cnt++;
                if (we_cnt == 1) begin
                    we_lat = i;
                    we_addr = ram_addr;
                    we_data = ram_wdata;
                end
            end
            if (load_ack) begin
                if (ack_first == 0) ack_first = i;
                ack_last = i;
            end
            if (cpu_rst_n) rst_hi++;
            if (i == hi) load_strobe = 1'b0;
        end
        full_end = int'(full);
    endtask

    task automatic set_mode(input logic m);
        prog_mode = m;
        mode_lat = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (mode_lat < 0 && cpu_rst_n == !m) mode_lat = i;
        end
    endtask

    initial begin
        prog_mode = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_load_ack", load_ack, 0);
        chk("rst_full", full, 0);
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("prog_cpu_rst_n", cpu_rst_n, 0);

        // three bytes
        send(8'h1A, 4, 4);
        chk("b0_cnt", we_cnt, 1); chk("b0_lat", we_lat, SS + 2);
        chk("b0_addr", we_addr, 0); chk("b0_data", we_data, 8'h1A);
        chk("b0_rst", rst_hi, 0);
        send(8'h2B, 4, 4);
        chk("b1_cnt", we_cnt, 1); chk("b1_lat", we_lat, SS + 2);
        chk("b1_addr", we_addr, 1); chk("b1_data", we_data, 8'h2B);
        chk("b1_rst", rst_hi, 0);
        send(8'h3C, 4, 4);
        chk("b2_cnt", we_cnt, 1); chk("b2_lat", we_lat, SS + 2);
        chk("b2_addr", we_addr, 2); chk("b2_data", we_data, 8'h3C);
        chk("b2_rst", rst_hi, 0); chk("b2_full", full_end, 0);

        // leave program mode, strobe while running
        set_mode(1'b0);
        chk("run_lat", mode_lat, SS + 1);
        send(8'h99, 4, 4);
        chk("run_no_we", we_cnt, 0);
        chk("run_rst_hi", rst_hi, 8);

        // re-enter and write one byte
        set_mode(1'b1);
        chk("prog_lat", mode_lat, SS + 1);
        send(8'h77, 4, 4);
        chk("re_cnt", we_cnt, 1); chk("re_addr", we_addr, 0);
        chk("re_data", we_data, 8'h77); chk("re_full", full_end, 0);

        // strobe held high
        send(8'h55, 20, 6);
        chk("hold_cnt", we_cnt, 1); chk("hold_addr", we_addr, 1);
        chk("hold_data", we_data, 8'h55);
        chk("hold_ack_first", ack_first, SS + 2);
        chk("hold_ack_last", ack_last, 20 + SS);

        // fill all 16 locations then overflow
        set_mode(1'b0);
        set_mode(1'b1);
        for (int k = 0; k < 16; k++) begin
            send(8'(k), 4, 4);
            chk($sformatf("fill%0d_cnt", k), we_cnt, 1);
            chk($sformatf("fill%0d_addr", k), we_addr, k);
            chk($sformatf("fill%0d_data", k), we_data, k);
            chk($sformatf("fill%0d_full", k), full_end, (k == 15) ? 1 : 0);
        end
        send(8'hFF, 4, 4);
        chk("ovf_cnt", we_cnt, 0);
        chk("ovf_ack", ack_first, 0);
        chk("ovf_full", full_end, 1);

        // asynchronous reset while ram_we is high
        set_mode(1'b0);
        set_mode(1'b1);
        chk("arst_full_clr", full, 0);
        load_data = 8'hA5;
        load_strobe = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick();
            if (ram_we) found = 1;
        end
        chk("arst_we_seen", found, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_we", ram_we, 0);
        chk("arst_cpu", cpu_rst_n, 0);
        chk("arst_ack", load_ack, 0);
        load_strobe = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        send(8'h3E, 4, 4);
        chk("post_cnt", we_cnt, 1); chk("post_addr", we_addr, 0);
        chk("post_data", we_data, 8'h3E); chk("post_full", full_end, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream stage of the 8-bit CPU RAM. Accepts program bytes from the chip's dedicated inputs and writes them into the 16-byte RAM through a strobe handshake.
- Holds the CPU core in reset while loading. Releases it once the host leaves program mode.
- Sits between the pad-level ui_in/uio_in pins and the RAM write port. It also gates the core reset seen by the control block, PC, IR and registers.

Parameters:
- RAM_BYTES, 16, number of RAM locations to fill; must equal the RAM size.
- ADDR_W, 4, width of the RAM address; RAM_BYTES <= 2**ADDR_W.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous pin input (prog_mode, load_strobe); minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- prog_mode  input  1  host level: 1 = load program, 0 = run; asynchronous to clk.
- load_strobe  input  1  host write strobe; asynchronous to clk; one byte per rising edge.
- load_data  input  8  program byte; host holds it stable from strobe rise until strobe fall.
- ram_we  output  1  one-cycle RAM write pulse.
- ram_addr  output  ADDR_W  RAM write address.
- ram_wdata  output  8  RAM write data.
- load_ack  output  1  high from the write cycle until the synchronized strobe falls.
- full  output  1  all RAM_BYTES locations written since entering program mode.
- cpu_rst_n  output  1  active-low reset to the CPU core.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ram_we=0, ram_addr=0, ram_wdata=0, load_ack=0, full=0, cpu_rst_n=0.
  - Sync chains cleared to 0; state=IDLE; write pointer ptr=0.
- Synchronization: prog_s and strobe_s are the last sync-stage outputs. strobe_rise = strobe_s & ~strobe_s_d (one extra flop).
- State IDLE:
  - cpu_rst_n=0.
  - Next cycle goes to PROG if prog_s=1, else RUN.
- State PROG (waiting for a byte):
  - cpu_rst_n=0.
  - On strobe_rise with full=0: capture load_data into ram_wdata and go to WRITE.
  - On strobe_rise with full=1: go to HOLD; no write, load_ack is not asserted.
  - prog_s=0 takes priority over strobe_rise: go to RUN.
- State WRITE (exactly one cycle):
  - ram_we=1, ram_addr=ptr, load_ack=1.
  - Next cycle: ptr increments. If ptr was RAM_BYTES-1, ptr wraps to 0 and full is set.
  - Then go to HOLD.
- State HOLD:
  - load_ack stays 1 only if this HOLD follows a write.
  - Wait for strobe_s=0, then go to PROG with load_ack=0. A strobe held high never produces a second write.
  - prog_s=0 here: go to RUN immediately, load_ack=0.
- State RUN:
  - cpu_rst_n=1, registered, with no glitch.
  - prog_s=1: go to PROG. ptr=0, full=0, and cpu_rst_n=0 on the same edge.
  - Strobes are ignored.
- Latency: pin strobe rise to ram_we=1 is SYNC_STAGES+2 clk cycles. A pin prog_mode change reaches the cpu_rst_n change in SYNC_STAGES+1 cycles.
- Outputs: all registered. ram_addr and ram_wdata hold their last values outside WRITE. RAM samples only on ram_we.
- rst_n asserted mid-WRITE: the write is aborted, ram_we drops asynchronously, and RAM contents are not altered by the loader.
- Program mode re-entered without reset: reload starts at address 0. Previous RAM contents persist until overwritten.

Test Plan:
- Reset then prog_mode=1. Send bytes 0x1A, 0x2B, 0x3C with strobe high for 4 cycles and low for 4 cycles. Required: three ram_we pulses at addr 0,1,2 with matching data; each pulse lands SYNC_STAGES+2 cycles after its strobe; cpu_rst_n=0 throughout; full=0.
- Load 16 bytes 0x00..0x0F, then a 17th byte 0xFF. Required: full=1 after the 16th write; the 17th strobe produces no ram_we and load_ack stays 0; ptr reads 0.
- Hold strobe high for 20 cycles with data 0x55. Required: exactly one ram_we; load_ack high from the write cycle until SYNC_STAGES cycles after strobe falls.
- After 3 bytes, drop prog_mode. Required: cpu_rst_n rises SYNC_STAGES+1 cycles later; strobes during RUN produce no ram_we.
- From RUN, raise prog_mode and send 0x77. Required: cpu_rst_n falls; write lands at addr 0; full=0.
- Assert rst_n=0 in the same cycle ram_we=1. Required: ram_we, cpu_rst_n and load_ack go 0 without waiting for clk; after release the loader returns to IDLE with ptr=0.
